// File: rtl/fsm_count_pkg.sv
// Shared types and constants for the two-digit BCD seconds counter.
package fsm_count_pkg;

  // Controller states: paused/initial, incrementing, terminal at 59.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Highest legal value of each digit before it wraps.
  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // True when the next increment lands the count on 59.
  function automatic logic is_pre_terminal(input logic [3:0] tens,
                                           input logic [3:0] units);
    return (tens == TENS_MAX) && (units == (UNITS_MAX - 4'd1));
  endfunction

endpackage

// File: rtl/fsm_count_bcd_digit.sv
// One registered BCD digit: increments when enabled, wraps to zero after MAX
// and raises carry on the enabled wrap. Codes above MAX also wrap, so a
// corrupted digit recovers on its next increment.
module fsm_count_bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;
  logic       at_max;

  assign at_max = (q_q >= MAX);
  assign carry  = en && at_max;
  assign q      = q_q;

  // Next digit value: hold, increment, or wrap to zero with carry.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = at_max ? 4'd0 : (q_q + 4'd1);
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/fsm_count.sv
// Two-digit BCD counter 00..59 with a small controller: counts while start
// is high, pauses while low, and locks at 59 with F set until reset.
module fsm_count
  import fsm_count_pkg::*;
(
  input  logic       start,
  input  logic       clk,
  input  logic       reset,
  output logic       F,
  output logic [3:0] units,
  output logic [3:0] tens
);

  state_t     state_q;
  state_t     state_d;
  logic       f_q;
  logic       f_d;
  logic       inc_en;
  logic       units_carry;
  logic       tens_carry;
  logic [3:0] units_val;
  logic [3:0] tens_val;

  // The count may only advance outside the terminal state.
  assign inc_en = start && (state_q != DONE);

  fsm_count_bcd_digit #(.MAX(UNITS_MAX)) u_units (
    .clk   (clk),
    .reset (reset),
    .en    (inc_en),
    .q     (units_val),
    .carry (units_carry)
  );

  fsm_count_bcd_digit #(.MAX(TENS_MAX)) u_tens (
    .clk   (clk),
    .reset (reset),
    .en    (units_carry),
    .q     (tens_val),
    .carry (tens_carry)
  );

  // Next state and finish flag. Any increment that lands on 59 enters DONE,
  // including a resume from a pause at 58, so the count can never pass 59.
  always_comb begin
    state_d = state_q;
    f_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = is_pre_terminal(tens_val, units_val) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (!start) begin
          state_d = IDLE;
        end else if (is_pre_terminal(tens_val, units_val)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    f_d = (state_d == DONE);
  end

  // State and flag registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      f_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
    end
  end

  assign F     = f_q;
  assign units = units_val;
  assign tens  = tens_val;

  // The tens digit never wraps in normal operation; its carry is unused.
  logic unused_tens_carry;
  assign unused_tens_carry = tens_carry;

endmodule

// File: tb/tb_fsm_count.sv
// Self-checking bench for fsm_count: table of directed segments, hand-written
// async-reset sequence, and a randomized run against a behavioural model.
module tb_fsm_count;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       F;
  logic [3:0] units;
  logic [3:0] tens;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: the count as a plain integer seconds value.
  int m_count = 0;
  bit m_done  = 1'b0;

  always #5 clk = ~clk;

  fsm_count dut (
    .start (start),
    .clk   (clk),
    .reset (reset),
    .F     (F),
    .units (units),
    .tens  (tens)
  );

  typedef struct {
    logic       rst;
    logic       st;
    int         edges;
    logic [3:0] exp_tens;
    logic [3:0] exp_units;
    logic       exp_f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input int n,
                              input int t, input int u, input logic f);
    vec_t v;
    v.rst = r; v.st = s; v.edges = n;
    v.exp_tens = 4'(t); v.exp_units = 4'(u); v.exp_f = f;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got F=%0b tens=%0d units=%0d, need F=%0b tens=%0d units=%0d",
               name, got[8], got[7:4], got[3:0], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  function automatic logic [8:0] model_vec();
    logic [8:0] v;
    v[8]   = m_done;
    v[7:4] = 4'(m_count / 10);
    v[3:0] = 4'(m_count % 10);
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic s);
    if (r) begin
      m_count = 0;
      m_done  = 1'b0;
    end else if (!m_done && s) begin
      m_count = m_count + 1;
      if (m_count == 59) m_done = 1'b1;
    end
  endtask

  // One clock edge with given inputs, then check against the model.
  task automatic tick(input logic r, input logic s, input string tag);
    reset = r;
    start = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    cmp(tag, {F, tens, units}, model_vec());
  endtask

  initial begin
    // Async reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    m_count = 0; m_done = 1'b0;
    cmp("reset_no_clock", {F, tens, units}, 9'd0);
    @(posedge clk); #1;

    vecs.push_back(mk(1, 0, 2, 0, 0, 0));   // reset hold
    vecs.push_back(mk(0, 1, 9, 0, 9, 0));   // up to 09
    vecs.push_back(mk(0, 1, 1, 1, 0, 0));   // carry 09 -> 10
    vecs.push_back(mk(0, 1, 2, 1, 2, 0));   // 12 after 12 edges
    vecs.push_back(mk(0, 1, 8, 2, 0, 0));   // 20
    vecs.push_back(mk(0, 0, 5, 2, 0, 0));   // pause holds 20
    vecs.push_back(mk(0, 1, 5, 2, 5, 0));   // resume -> 25
    vecs.push_back(mk(1, 0, 1, 0, 0, 0));   // reset
    vecs.push_back(mk(0, 1, 58, 5, 8, 0));  // 58, F still low
    vecs.push_back(mk(0, 1, 1, 5, 9, 1));   // 59th edge -> DONE
    vecs.push_back(mk(0, 1, 10, 5, 9, 1));  // stays at 59
    vecs.push_back(mk(0, 0, 3, 5, 9, 1));   // start low keeps 59
    vecs.push_back(mk(0, 1, 2, 5, 9, 1));   // start high keeps 59
    vecs.push_back(mk(1, 0, 1, 0, 0, 0));   // reset from DONE
    vecs.push_back(mk(0, 0, 3, 0, 0, 0));   // idle keeps 00
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));   // counts from 01
    vecs.push_back(mk(1, 0, 1, 0, 0, 0));   // long run: reset
    vecs.push_back(mk(0, 1, 20, 2, 0, 0));  // 20 enabled
    vecs.push_back(mk(0, 0, 5, 2, 0, 0));   // 5 paused
    vecs.push_back(mk(0, 1, 50, 5, 9, 1));  // 50 enabled -> DONE
    vecs.push_back(mk(1, 0, 1, 0, 0, 0));   // reset
    vecs.push_back(mk(0, 1, 58, 5, 8, 0));  // pause exactly at 58
    vecs.push_back(mk(0, 0, 4, 5, 8, 0));
    vecs.push_back(mk(0, 1, 1, 5, 9, 1));   // resume lands on 59 -> DONE
    vecs.push_back(mk(0, 1, 3, 5, 9, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      for (int e = 0; e < vecs[i].edges; e++) begin
        tick(vecs[i].rst, vecs[i].st, $sformatf("vec%0d_edge%0d", i, e));
        if (F === 1'b1 && tens !== 4'd5) begin
          n_cmp++; n_bad++;
          $display("FAIL f_without_tens5: F=1 tens=%0d units=%0d", tens, units);
        end
      end
      cmp($sformatf("vec%0d_final", i), {F, tens, units},
          {vecs[i].exp_f, vecs[i].exp_tens, vecs[i].exp_units});
      $display("vec %0d: rst=%0b start=%0b edges=%0d -> F=%0b tens=%0d units=%0d",
               i, vecs[i].rst, vecs[i].st, vecs[i].edges, F, tens, units);
    end

    // Async reset mid-count, between edges.
    for (int e = 0; e < 7; e++) tick(1'b0, 1'b1, "pre_async");
    #2 reset = 1'b1;
    #1;
    m_count = 0; m_done = 1'b0;
    cmp("async_mid_count", {F, tens, units}, 9'd0);
    tick(1'b0, 1'b1, "after_async");
    cmp("after_async_is_01", {F, tens, units}, 9'h001);

    // Async reset while in DONE, between edges.
    for (int e = 0; e < 60; e++) tick(1'b0, 1'b1, "to_done");
    cmp("done_reached", {F, tens, units}, 9'h159);
    #2 reset = 1'b1;
    #1;
    m_count = 0; m_done = 1'b0;
    cmp("async_in_done", {F, tens, units}, 9'd0);
    tick(1'b0, 1'b0, "post_done_idle");

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic s;
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 3) != 0);
      tick(r, s, $sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_count.md
Name: fsm_count

Overview:
- Two-digit BCD seconds-style counter (00..59) controlled by a small FSM.
- Counts up once per clock while `start` is high and holds while `start` is low.
- On reaching 59 it stops, asserts the finish flag `F` and stays there until reset.
- Used as a stand-alone timer/counter leaf block; outputs drive display or status logic.

Parameters:
- None. Digit limits are fixed constants (see Decomposition).

Ports:
- clk  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  count enable; high = count, low = pause
- F  output  1  finish flag; high while the counter is held at 59
- units  output  4  BCD units digit, 0..9
- tens  output  4  BCD tens digit, 0..5
- Module port declaration order is fixed: start, clk, reset, F, units, tens. Instances connect positionally.

Behaviour:
- One clock; reset is asynchronous and active-high.
  - While `reset`=1: state=IDLE, units=0, tens=0, F=0, independent of clk.
- All outputs are registered. No combinational path from `start` to the outputs.
- States:
  - IDLE: paused or initial.
  - COUNT: incrementing.
  - DONE: terminal at 59.
- Transitions, evaluated at each rising clk edge:
  - IDLE: start=1 -> COUNT, and the count increments on this same edge. start=0 -> stay IDLE, count held.
  - COUNT: start=1 and count != 58 -> increment, stay COUNT. start=1 and count==58 -> count becomes 59, go DONE, F set on the same edge. start=0 -> IDLE, count held with no increment.
  - DONE: hold units=9, tens=5, F=1 regardless of `start`. Only `reset` leaves DONE.
- Increment rule (BCD):
  - units<9 -> units+1.
  - units==9 -> units=0, tens+1.
  - tens never exceeds 5, and the count never wraps from 59 to 00.
- Increment latency: the count advances on every rising edge at which `start` is sampled 1 (outside DONE), so 59 is reached after 59 enabled edges from 00.
- Pausing: start low for any number of cycles freezes units/tens. Resuming continues from the frozen value.
- F:
  - 1 exactly when the state is DONE, which implies tens==5 and units==9.
  - 0 in all other states, including counts 50..58.
- Reset mid-count or in DONE: outputs clear immediately and asynchronously to 00, F=0. Counting resumes from 00 on the first edge after reset deasserts with start=1.
- Reset and a clock edge together: reset wins.
- Non-BCD digit codes (10..15) are unreachable. If ever present, the next increment forces units=0 and carries.

Decomposition:
- Package fsm_count_pkg:
  - state enum {IDLE, COUNT, DONE}, 2-bit.
  - localparams UNITS_MAX=4'd9, TENS_MAX=4'd5.
- Optional sub-module bcd_digit: 4-bit BCD digit with enable, wrap at a max value, and carry-out. Instantiate it for units (max 9) and tens (max 5). The FSM and terminal-count detect stay in fsm_count.

Test Plan:
- Reset hold: reset=1 for 2 cycles with start=0 -> units=0, tens=0, F=0. Assert reset asynchronously between edges -> outputs clear with no clock edge.
- Basic count: release reset, start=1 for 12 edges -> tens=1, units=2, F=0. Check the BCD carry at 09 -> 10.
- Pause/resume: count to 20 (20 edges), start=0 for 5 edges -> holds 20. start=1 for 5 edges -> 25, with no skipped or extra increment.
- Terminal: from 00, start=1 for 59 edges -> tens=5, units=9, F=1 on the 59th edge. After 10 more edges with start=1 it still reads 59, F=1. Toggling start low/high keeps 59, F=1. F=0 for every count 50..58.
- Reset from DONE: in DONE, pulse reset for 1 cycle -> 00, F=0. start=0 afterwards keeps 00. start=1 then counts from 01.
- Long run matching the system use case: 20 edges enabled, 5 paused, 50 enabled -> ends in DONE with F=1 and tens==5. Any F=1 with tens!=5 is a failure.
